// File: rtl/slink_apb_ini_engine.sv
// S-Link APB initiator engine: buffers decoded request packets, runs them one
// at a time as APB setup/access transfers and returns a typed response packet.
module slink_apb_ini_engine #(
  parameter int         ADDR_WIDTH       = 32,
  parameter int         DATA_WIDTH       = 32,
  parameter int         REQ_DEPTH        = 4,
  parameter int         TIMEOUT_WIDTH    = 16,
  parameter logic [7:0] APB_READ_DT      = 8'h24,
  parameter logic [7:0] APB_READ_RSP_DT  = 8'h25,
  parameter logic [7:0] APB_WRITE_DT     = 8'h26,
  parameter logic [7:0] APB_WRITE_RSP_DT = 8'h27
) (
  input  logic                                           apb_clk,
  input  logic                                           apb_reset,
  input  logic                                           enable,
  input  logic [TIMEOUT_WIDTH-1:0]                       swi_timeout_cycles,
  input  logic [2:0]                                     swi_pprot,
  input  logic                                           req_valid,
  output logic                                           req_ready,
  input  logic [7:0]                                     req_data_id,
  input  logic [ADDR_WIDTH+DATA_WIDTH+DATA_WIDTH/8-1:0]  req_payload,
  output logic [ADDR_WIDTH-1:0]                          apb_paddr,
  output logic                                           apb_pwrite,
  output logic                                           apb_psel,
  output logic                                           apb_penable,
  output logic [DATA_WIDTH-1:0]                          apb_pwdata,
  output logic [DATA_WIDTH/8-1:0]                        apb_pstrb,
  output logic [2:0]                                     apb_pprot,
  input  logic [DATA_WIDTH-1:0]                          apb_prdata,
  input  logic                                           apb_pready,
  input  logic                                           apb_pslverr,
  output logic                                           rsp_valid,
  input  logic                                           rsp_ready,
  output logic [7:0]                                     rsp_data_id,
  output logic [15:0]                                    rsp_word_count,
  output logic [DATA_WIDTH+7:0]                          rsp_payload,
  output logic                                           invalid_pkt,
  output logic [7:0]                                     invalid_cnt
);

  localparam int SW   = DATA_WIDTH / 8;
  localparam int PW   = ADDR_WIDTH + DATA_WIDTH + SW;
  localparam int PTRW = $clog2(REQ_DEPTH);
  localparam logic [PTRW:0]          CNT_ONE  = 1;
  localparam logic [PTRW:0]          CNT_FULL = REQ_DEPTH;
  localparam logic [PTRW-1:0]        PTR_ONE  = 1;
  localparam logic [TIMEOUT_WIDTH-1:0] TO_ONE = 1;
  localparam logic [15:0]            RD_WC    = 16'(SW + 1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

  state_t state, state_nxt;

  // request FIFO
  logic [7:0]      fifo_id [REQ_DEPTH];
  logic [PW-1:0]   fifo_pl [REQ_DEPTH];
  logic [PTRW-1:0] wr_ptr, rd_ptr;
  logic [PTRW:0]   count, count_nxt;
  logic            full_q, empty;
  logic            push, pop;

  logic [7:0]      head_id;
  logic [PW-1:0]   head_pl;
  logic            head_ok, head_wr, can_pop;

  // FSM control strobes
  logic load, drop, finish, wd_clr, wd_inc, expire;

  logic [TIMEOUT_WIDTH-1:0] wd_cnt;
  logic                     write_q;
  logic [7:0]               status;

  assign empty     = (count == '0);
  assign req_ready = enable && !full_q;
  assign push      = req_valid && req_ready;
  assign head_id   = fifo_id[rd_ptr];
  assign head_pl   = fifo_pl[rd_ptr];
  assign head_wr   = (head_id == APB_WRITE_DT);
  assign head_ok   = head_wr || (head_id == APB_READ_DT);
  assign can_pop   = enable && !empty;

  // Expiry only fires on the last allowed ACCESS cycle; pready wins if both.
  assign expire = !apb_pready && (swi_timeout_cycles != '0) &&
                  (wd_cnt == swi_timeout_cycles - TO_ONE);

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CNT_ONE;
      2'b01:   count_nxt = count - CNT_ONE;
      default: count_nxt = count;
    endcase
  end

  // FIFO storage, no reset needed: only entries below count are ever read
  always_ff @(posedge apb_clk) begin
    if (push) begin
      fifo_id[wr_ptr] <= req_data_id;
      fifo_pl[wr_ptr] <= req_payload;
    end
  end

  // FIFO pointers, occupancy and registered full flag
  always_ff @(posedge apb_clk) begin
    if (apb_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      count  <= count_nxt;
      full_q <= (count_nxt == CNT_FULL);
    end
  end

  // state register
  always_ff @(posedge apb_clk) begin
    if (apb_reset) state <= S_IDLE;
    else           state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (can_pop && head_ok) state_nxt = S_SETUP;
      S_SETUP:  state_nxt = S_ACCESS;
      S_ACCESS: if (apb_pready || expire) state_nxt = S_RESP;
      S_RESP:   if (rsp_ready) state_nxt = (can_pop && head_ok) ? S_SETUP : S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // control strobes; invalid heads are only ever dropped from IDLE
  always_comb begin
    pop    = 1'b0;
    load   = 1'b0;
    drop   = 1'b0;
    finish = 1'b0;
    wd_clr = 1'b0;
    wd_inc = 1'b0;
    case (state)
      S_IDLE: if (can_pop) begin
        pop  = 1'b1;
        load = head_ok;
        drop = !head_ok;
      end
      S_SETUP:  wd_clr = 1'b1;
      S_ACCESS: begin
        finish = apb_pready || expire;
        wd_inc = !(apb_pready || expire);
      end
      S_RESP: if (rsp_ready && can_pop && head_ok) begin
        pop  = 1'b1;
        load = 1'b1;
      end
      default: ;
    endcase
  end

  // APB phase flags, registered from the next state
  always_ff @(posedge apb_clk) begin
    if (apb_reset) begin
      apb_psel    <= 1'b0;
      apb_penable <= 1'b0;
    end else begin
      apb_psel    <= (state_nxt == S_SETUP) || (state_nxt == S_ACCESS);
      apb_penable <= (state_nxt == S_ACCESS);
    end
  end

  // transfer fields: loaded on pop, cleared when the transfer ends so they
  // read 0 whenever psel is low
  always_ff @(posedge apb_clk) begin
    if (apb_reset || finish) begin
      apb_paddr  <= '0;
      apb_pwdata <= '0;
      apb_pstrb  <= '0;
      apb_pprot  <= '0;
      apb_pwrite <= 1'b0;
    end else if (load) begin
      apb_paddr  <= head_pl[ADDR_WIDTH-1:0];
      apb_pwdata <= head_wr ? head_pl[ADDR_WIDTH +: DATA_WIDTH] : '0;
      apb_pstrb  <= head_wr ? head_pl[ADDR_WIDTH+DATA_WIDTH +: SW] : '0;
      apb_pprot  <= swi_pprot;
      apb_pwrite <= head_wr;
    end
  end

  // write_q survives the end of the transfer to type the response
  always_ff @(posedge apb_clk) begin
    if (apb_reset)  write_q <= 1'b0;
    else if (load)  write_q <= head_wr;
  end

  // PREADY watchdog counter
  always_ff @(posedge apb_clk) begin
    if (apb_reset || wd_clr) wd_cnt <= '0;
    else if (wd_inc)         wd_cnt <= wd_cnt + TO_ONE;
  end

  // finishing without pready can only mean the watchdog expired
  assign status = {6'b0, !apb_pready, apb_pready && apb_pslverr};

  // response packet, held until accepted
  always_ff @(posedge apb_clk) begin
    if (apb_reset) begin
      rsp_valid      <= 1'b0;
      rsp_data_id    <= '0;
      rsp_word_count <= '0;
      rsp_payload    <= '0;
    end else begin
      rsp_valid <= (state_nxt == S_RESP);
      if (finish) begin
        if (write_q) begin
          rsp_data_id    <= APB_WRITE_RSP_DT;
          rsp_word_count <= 16'd1;
          rsp_payload    <= {{DATA_WIDTH{1'b0}}, status};
        end else begin
          rsp_data_id    <= APB_READ_RSP_DT;
          rsp_word_count <= RD_WC;
          rsp_payload    <= {status, apb_pready ? apb_prdata : {DATA_WIDTH{1'b0}}};
        end
      end
    end
  end

  // dropped-packet pulse and saturating counter
  always_ff @(posedge apb_clk) begin
    if (apb_reset) begin
      invalid_pkt <= 1'b0;
      invalid_cnt <= '0;
    end else begin
      invalid_pkt <= drop;
      if (drop && invalid_cnt != 8'hFF) invalid_cnt <= invalid_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_slink_apb_ini_engine.sv
// Bench for slink_apb_ini_engine: APB target model plus response scoreboard.
module tb_slink_apb_ini_engine;

  logic        apb_clk = 1'b0;
  logic        apb_reset, enable;
  logic [15:0] swi_timeout_cycles;
  logic [2:0]  swi_pprot;
  logic        req_valid, req_ready;
  logic [7:0]  req_data_id;
  logic [67:0] req_payload;
  logic [31:0] apb_paddr, apb_pwdata, apb_prdata;
  logic        apb_pwrite, apb_psel, apb_penable, apb_pready, apb_pslverr;
  logic [3:0]  apb_pstrb;
  logic [2:0]  apb_pprot;
  logic        rsp_valid, rsp_ready;
  logic [7:0]  rsp_data_id;
  logic [15:0] rsp_word_count;
  logic [39:0] rsp_payload;
  logic        invalid_pkt;
  logic [7:0]  invalid_cnt;

  slink_apb_ini_engine dut (
    .apb_clk(apb_clk), .apb_reset(apb_reset), .enable(enable),
    .swi_timeout_cycles(swi_timeout_cycles), .swi_pprot(swi_pprot),
    .req_valid(req_valid), .req_ready(req_ready), .req_data_id(req_data_id),
    .req_payload(req_payload), .apb_paddr(apb_paddr), .apb_pwrite(apb_pwrite),
    .apb_psel(apb_psel), .apb_penable(apb_penable), .apb_pwdata(apb_pwdata),
    .apb_pstrb(apb_pstrb), .apb_pprot(apb_pprot), .apb_prdata(apb_prdata),
    .apb_pready(apb_pready), .apb_pslverr(apb_pslverr), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data_id(rsp_data_id), .rsp_word_count(rsp_word_count),
    .rsp_payload(rsp_payload), .invalid_pkt(invalid_pkt), .invalid_cnt(invalid_cnt)
  );

  always #5 apb_clk = ~apb_clk;

  int cyc = 0;
  always @(posedge apb_clk) cyc <= cyc + 1;

  // APB target: cfg_wait wait states, optional hang, fixed or address-echo data
  logic [3:0]  cfg_wait = 0;
  logic        cfg_hang = 0, cfg_err = 0, cfg_echo = 0;
  logic [31:0] cfg_rdata = 0;
  logic [3:0]  acc_cnt = 0;
  always @(posedge apb_clk)
    if (!(apb_psel && apb_penable) || apb_pready) acc_cnt <= 0;
    else acc_cnt <= acc_cnt + 1;
  assign apb_pready  = apb_psel && apb_penable && !cfg_hang && (acc_cnt == cfg_wait);
  assign apb_prdata  = cfg_echo ? apb_paddr : cfg_rdata;
  assign apb_pslverr = apb_pready && cfg_err;

  typedef struct { logic [7:0] id; logic [15:0] wc; logic [39:0] pl; } exp_t;
  exp_t sbq[$];
  int total = 0, bad = 0;
  int hs_cyc[8];

  // drive one request; expected response derived from the target config
  task automatic push(input logic [7:0] id, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [3:0] strb);
    exp_t e;
    logic [7:0] st;
    int w;
    req_valid = 1; req_data_id = id; req_payload = {strb, wd, addr};
    w = 0;
    while (!req_ready && w < 50) begin @(negedge apb_clk); w++; end
    total++;
    if (!req_ready) begin bad++; $display("FAIL push_ready: req_ready=%b required 1", req_ready); end
    @(negedge apb_clk);
    req_valid = 0;
    st = cfg_hang ? 8'h02 : {7'b0, cfg_err};
    if (id == 8'h26) begin
      e.id = 8'h27; e.wc = 16'd1; e.pl = {32'h0, st}; sbq.push_back(e);
    end else if (id == 8'h24) begin
      e.id = 8'h25; e.wc = 16'd5;
      e.pl = {st, cfg_hang ? 32'h0 : (cfg_echo ? addr : cfg_rdata)};
      sbq.push_back(e);
    end
  endtask

  task automatic test_reset();
    apb_reset = 1; enable = 1; swi_timeout_cycles = 0; swi_pprot = 3'b101;
    req_valid = 0; req_data_id = 0; req_payload = 0; rsp_ready = 1;
    repeat (3) @(negedge apb_clk);
    total++;
    if ({apb_psel, apb_penable, apb_pwrite, apb_pprot} !== 6'b0) begin
      bad++; $display("FAIL reset_apb_ctl: got %b required 000000", {apb_psel, apb_penable, apb_pwrite, apb_pprot});
    end
    total++;
    if ({apb_paddr, apb_pwdata, apb_pstrb} !== 68'h0) begin
      bad++; $display("FAIL reset_apb_data: got %h required 0", {apb_paddr, apb_pwdata, apb_pstrb});
    end
    total++;
    if ({rsp_valid, rsp_data_id, rsp_word_count, rsp_payload} !== 65'h0) begin
      bad++; $display("FAIL reset_rsp: got %h required 0", {rsp_valid, rsp_data_id, rsp_word_count, rsp_payload});
    end
    total++;
    if ({invalid_pkt, invalid_cnt} !== 9'h0) begin
      bad++; $display("FAIL reset_invalid: got %h required 0", {invalid_pkt, invalid_cnt});
    end
    apb_reset = 0;
    @(negedge apb_clk);
    total++;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready: got %b required 1", req_ready); end
  endtask

  task automatic test_write();
    exp_t e; int w;
    cfg_wait = 0; cfg_err = 0; cfg_hang = 0;
    push(8'h26, 32'h1000, 32'hCAFEF00D, 4'hF);
    total++;
    if (apb_psel !== 1'b0) begin bad++; $display("FAIL wr_cycle1_psel: got %b required 0", apb_psel); end
    @(negedge apb_clk);
    total++;
    if ({apb_psel, apb_penable, apb_pwrite, apb_paddr, apb_pwdata, apb_pstrb, apb_pprot} !==
        {1'b1, 1'b0, 1'b1, 32'h1000, 32'hCAFEF00D, 4'hF, 3'b101}) begin
      bad++; $display("FAIL wr_setup: got sel=%b en=%b wr=%b a=%h d=%h s=%h p=%b", apb_psel, apb_penable,
                      apb_pwrite, apb_paddr, apb_pwdata, apb_pstrb, apb_pprot);
    end
    @(negedge apb_clk);
    total++;
    if ({apb_psel, apb_penable, apb_paddr} !== {2'b11, 32'h1000}) begin
      bad++; $display("FAIL wr_access: got sel=%b en=%b a=%h required 1 1 1000", apb_psel, apb_penable, apb_paddr);
    end
    @(negedge apb_clk);
    total++;
    if ({rsp_valid, apb_psel, apb_paddr, apb_pwdata} !== {2'b10, 64'h0}) begin
      bad++; $display("FAIL wr_latency: got rsp_valid=%b psel=%b a=%h d=%h required 1 0 0 0", rsp_valid, apb_psel,
                      apb_paddr, apb_pwdata);
    end
    for (int k = 0; k < 1; k++) begin
      w = 0;
      while (!(rsp_valid && rsp_ready) && w < 100) begin @(negedge apb_clk); w++; end
      total++;
      if (w >= 100 || sbq.size() == 0) begin bad++; $display("FAIL wr_rsp_wait: no response, queue=%0d", sbq.size()); end
      else begin
        e = sbq.pop_front();
        if ({rsp_data_id, rsp_word_count, rsp_payload} !== {e.id, e.wc, e.pl}) begin
          bad++; $display("FAIL wr_rsp: got %h/%0d/%h required %h/%0d/%h", rsp_data_id, rsp_word_count,
                          rsp_payload, e.id, e.wc, e.pl);
        end
      end
      @(negedge apb_clk);
    end
  endtask

  task automatic test_read();
    exp_t e; int w, n;
    cfg_wait = 2; cfg_err = 1; cfg_rdata = 32'h12345678;
    push(8'h24, 32'h20, 32'hFFFFFFFF, 4'hF);
    @(negedge apb_clk);
    total++;
    if ({apb_psel, apb_penable, apb_pwrite, apb_paddr, apb_pwdata, apb_pstrb} !== {3'b100, 32'h20, 32'h0, 4'h0}) begin
      bad++; $display("FAIL rd_setup: got sel=%b en=%b wr=%b a=%h d=%h s=%h", apb_psel, apb_penable, apb_pwrite,
                      apb_paddr, apb_pwdata, apb_pstrb);
    end
    @(negedge apb_clk);
    n = 0;
    while (apb_psel && apb_penable && n < 20) begin n++; @(negedge apb_clk); end
    total++;
    if (n != 3) begin bad++; $display("FAIL rd_access_len: got %0d required 3", n); end
    for (int k = 0; k < 1; k++) begin
      w = 0;
      while (!(rsp_valid && rsp_ready) && w < 100) begin @(negedge apb_clk); w++; end
      total++;
      if (w >= 100 || sbq.size() == 0) begin bad++; $display("FAIL rd_rsp_wait: no response, queue=%0d", sbq.size()); end
      else begin
        e = sbq.pop_front();
        if ({rsp_data_id, rsp_word_count, rsp_payload} !== {e.id, e.wc, e.pl}) begin
          bad++; $display("FAIL rd_rsp: got %h/%0d/%h required %h/%0d/%h", rsp_data_id, rsp_word_count,
                          rsp_payload, e.id, e.wc, e.pl);
        end
      end
      @(negedge apb_clk);
    end
    cfg_wait = 0; cfg_err = 0;
  endtask

  task automatic test_timeout();
    exp_t e; int w, n;
    swi_timeout_cycles = 16'd3; cfg_hang = 1; cfg_rdata = 32'hDEADBEEF;
    push(8'h24, 32'h40, 32'h0, 4'h0);
    repeat (2) @(negedge apb_clk);
    n = 0;
    while (apb_psel && apb_penable && n < 20) begin n++; @(negedge apb_clk); end
    total++;
    if (n != 3 || apb_psel !== 1'b0) begin
      bad++; $display("FAIL to_access_len: got %0d cycles psel=%b required 3 cycles psel=0", n, apb_psel);
    end
    for (int k = 0; k < 1; k++) begin
      w = 0;
      while (!(rsp_valid && rsp_ready) && w < 100) begin @(negedge apb_clk); w++; end
      total++;
      if (w >= 100 || sbq.size() == 0) begin bad++; $display("FAIL to_rsp_wait: no response, queue=%0d", sbq.size()); end
      else begin
        e = sbq.pop_front();
        if ({rsp_data_id, rsp_word_count, rsp_payload} !== {e.id, e.wc, e.pl}) begin
          bad++; $display("FAIL to_rsp: got %h/%0d/%h required %h/%0d/%h", rsp_data_id, rsp_word_count,
                          rsp_payload, e.id, e.wc, e.pl);
        end
      end
      @(negedge apb_clk);
    end
    swi_timeout_cycles = 0; cfg_hang = 0;
  endtask

  task automatic test_fifo_full();
    exp_t e; int w, n;
    rsp_ready = 0; cfg_echo = 1;
    for (int i = 0; i < 5; i++) push(8'h24, 32'h100 + 32'(i * 4), 32'h0, 4'h0);
    // a sixth request must not be taken while the FIFO is full
    req_valid = 1; req_data_id = 8'h26; req_payload = {4'hF, 32'h1, 32'h999};
    n = 0;
    repeat (3) begin if (req_ready) n++; @(negedge apb_clk); end
    req_valid = 0;
    total++;
    if (n != 0) begin bad++; $display("FAIL full_ready: req_ready high %0d cycles required 0", n); end
    rsp_ready = 1;
    for (int k = 0; k < 5; k++) begin
      w = 0;
      while (!(rsp_valid && rsp_ready) && w < 100) begin @(negedge apb_clk); w++; end
      total++;
      if (w >= 100 || sbq.size() == 0) begin bad++; $display("FAIL full_rsp_wait: no response, queue=%0d", sbq.size()); end
      else begin
        e = sbq.pop_front();
        hs_cyc[k] = cyc;
        if ({rsp_data_id, rsp_word_count, rsp_payload} !== {e.id, e.wc, e.pl}) begin
          bad++; $display("FAIL full_rsp%0d: got %h/%0d/%h required %h/%0d/%h", k, rsp_data_id, rsp_word_count,
                          rsp_payload, e.id, e.wc, e.pl);
        end
      end
      @(negedge apb_clk);
    end
    for (int k = 1; k < 5; k++) begin
      total++;
      if (hs_cyc[k] - hs_cyc[k-1] != 3) begin
        bad++; $display("FAIL full_throughput%0d: got %0d cycles required 3", k, hs_cyc[k] - hs_cyc[k-1]);
      end
    end
    n = 0;
    repeat (8) begin if (rsp_valid || apb_psel) n++; @(negedge apb_clk); end
    total++;
    if (n != 0) begin bad++; $display("FAIL full_extra: activity %0d cycles required 0", n); end
    cfg_echo = 0;
  endtask

  task automatic test_invalid();
    int n_inv, n_sel;
    push(8'h55, 32'h10, 32'h0, 4'h0);
    n_inv = 0; n_sel = 0;
    repeat (6) begin
      if (invalid_pkt) n_inv++;
      if (apb_psel) n_sel++;
      @(negedge apb_clk);
    end
    total++;
    if (n_inv != 1 || n_sel != 0 || invalid_cnt !== 8'd1) begin
      bad++; $display("FAIL inv_single: pulses=%0d psel=%0d cnt=%0d required 1 0 1", n_inv, n_sel, invalid_cnt);
    end
    req_valid = 1; req_data_id = 8'h55;
    repeat (300) @(negedge apb_clk);
    req_valid = 0;
    repeat (4) @(negedge apb_clk);
    total++;
    if (invalid_cnt !== 8'd255 || invalid_pkt !== 1'b0) begin
      bad++; $display("FAIL inv_saturate: cnt=%0d pulse=%b required 255 0", invalid_cnt, invalid_pkt);
    end
  endtask

  task automatic test_enable();
    exp_t e; int w, n;
    cfg_wait = 2; cfg_echo = 1; rsp_ready = 1;
    for (int i = 0; i < 3; i++) push(8'h24, 32'h200 + 32'(i * 4), 32'h0, 4'h0);
    w = 0;
    while (!(apb_psel && apb_penable) && w < 20) begin @(negedge apb_clk); w++; end
    enable = 0;
    for (int k = 0; k < 1; k++) begin
      w = 0;
      while (!(rsp_valid && rsp_ready) && w < 100) begin @(negedge apb_clk); w++; end
      total++;
      if (w >= 100 || sbq.size() == 0) begin bad++; $display("FAIL en_rsp_wait: no response, queue=%0d", sbq.size()); end
      else begin
        e = sbq.pop_front();
        if ({rsp_data_id, rsp_word_count, rsp_payload} !== {e.id, e.wc, e.pl}) begin
          bad++; $display("FAIL en_rsp_inflight: got %h/%0d/%h required %h/%0d/%h", rsp_data_id, rsp_word_count,
                          rsp_payload, e.id, e.wc, e.pl);
        end
      end
      @(negedge apb_clk);
    end
    n = 0;
    repeat (8) begin if (apb_psel || req_ready) n++; @(negedge apb_clk); end
    total++;
    if (n != 0) begin bad++; $display("FAIL en_hold: psel/req_ready high %0d cycles required 0", n); end
    enable = 1;
    for (int k = 0; k < 2; k++) begin
      w = 0;
      while (!(rsp_valid && rsp_ready) && w < 100) begin @(negedge apb_clk); w++; end
      total++;
      if (w >= 100 || sbq.size() == 0) begin bad++; $display("FAIL en_rsp_wait: no response, queue=%0d", sbq.size()); end
      else begin
        e = sbq.pop_front();
        if ({rsp_data_id, rsp_word_count, rsp_payload} !== {e.id, e.wc, e.pl}) begin
          bad++; $display("FAIL en_rsp_queued%0d: got %h/%0d/%h required %h/%0d/%h", k, rsp_data_id,
                          rsp_word_count, rsp_payload, e.id, e.wc, e.pl);
        end
      end
      @(negedge apb_clk);
    end
    cfg_wait = 0; cfg_echo = 0;
  endtask

  task automatic test_reset_mid();
    int w;
    cfg_hang = 1;
    push(8'h26, 32'h300, 32'h55AA55AA, 4'h3);
    w = 0;
    while (!(apb_psel && apb_penable) && w < 20) begin @(negedge apb_clk); w++; end
    apb_reset = 1;
    @(negedge apb_clk);
    total++;
    if ({apb_psel, apb_penable, apb_pwrite, rsp_valid, invalid_cnt} !== 12'h0) begin
      bad++; $display("FAIL mid_reset: sel=%b en=%b wr=%b rsp_valid=%b cnt=%0d required all 0", apb_psel,
                      apb_penable, apb_pwrite, rsp_valid, invalid_cnt);
    end
    apb_reset = 0; cfg_hang = 0;
    sbq.delete();
    @(negedge apb_clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_fifo_full();
    test_invalid();
    test_enable();
    test_reset_mid();
    total++;
    if (sbq.size() != 0) begin bad++; $display("FAIL sb_leftover: got %0d required 0", sbq.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
